// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master arbiter in front of the shared DRAM request port.
// Round-robin (or fixed) grant, registered DRAM request, completion routing, watchdog.
module dram_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_read,
    input  logic              m0_req_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_out,
    output logic [DATA_W-1:0] m0_data_in,
    output logic              m0_data_valid,
    output logic              m0_write_complete,
    output logic              m0_error,
    input  logic              m1_req_read,
    input  logic              m1_req_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_out,
    output logic [DATA_W-1:0] m1_data_in,
    output logic              m1_data_valid,
    output logic              m1_write_complete,
    output logic              m1_error,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_data_out,
    output logic              dram_req_read,
    output logic              dram_req_write,
    input  logic [DATA_W-1:0] dram_data_in,
    input  logic              dram_data_valid,
    input  logic              dram_write_complete,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        dv_q, dv_d;
    logic [1:0]        wc_q, wc_d;
    logic [1:0]        err_q, err_d;
    logic [CW-1:0]     wdog_q, wdog_d;

    logic req0, req1;
    logic win;
    logic win_wr;
    logic tmo;

    assign req0 = m0_req_read | m0_req_write;
    assign req1 = m1_req_read | m1_req_write;

    // watchdog fires on the BUSY edge that completes TIMEOUT cycles
    assign tmo = (TIMEOUT != 0) && (wdog_q == CW'(TIMEOUT - 1));

    // next-state: grant selection, completion routing, watchdog abort
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        dv_d     = 2'b00;
        wc_d     = 2'b00;
        err_d    = 2'b00;
        wdog_d   = wdog_q;
        win      = 1'b0;
        win_wr   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
                    end else begin
                        win = req1;
                    end
                    win_wr  = win ? m1_req_write : m0_req_write;
                    addr_d  = win ? m1_addr : m0_addr;
                    wdata_d = win ? m1_data_out : m0_data_out;
                    wr_d    = win_wr;
                    rd_d    = ~win_wr;
                    grant_d = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wdog_d = wdog_q + 1'b1;
                if (rd_q && dram_data_valid) begin
                    rd_d         = 1'b0;
                    dv_d[last_q] = 1'b1;
                    if (last_q) begin
                        rdata1_d = dram_data_in;
                    end else begin
                        rdata0_d = dram_data_in;
                    end
                    state_d = DONE;
                end else if (wr_q && dram_write_complete) begin
                    wr_d         = 1'b0;
                    wc_d[last_q] = 1'b1;
                    state_d      = DONE;
                end else if (tmo) begin
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    err_d[last_q] = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            dv_q     <= 2'b00;
            wc_q     <= 2'b00;
            err_q    <= 2'b00;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            dv_q     <= dv_d;
            wc_q     <= wc_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    assign dram_addr         = addr_q;
    assign dram_data_out     = wdata_q;
    assign dram_req_read     = rd_q;
    assign dram_req_write    = wr_q;
    assign grant             = grant_q;
    assign busy              = (state_q != IDLE);
    assign m0_data_in        = rdata0_q;
    assign m1_data_in        = rdata1_q;
    assign m0_data_valid     = dv_q[0];
    assign m1_data_valid     = dv_q[1];
    assign m0_write_complete = wc_q[0];
    assign m1_write_complete = wc_q[1];
    assign m0_error          = err_q[0];
    assign m1_error          = err_q[1];

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: transaction-level reference model driving a round-robin
// and a fixed-priority arbiter instance from shared random master traffic.
module tb_dram_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req_read, m0_req_write, m1_req_read, m1_req_write;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_data_out, m1_data_out;
    logic [DW-1:0] dram_data_in;
    logic          dram_data_valid, dram_write_complete;
    logic          resp;

    logic [DW-1:0] m0_data_in, m1_data_in;
    logic          m0_data_valid, m0_write_complete, m0_error;
    logic          m1_data_valid, m1_write_complete, m1_error;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_data_out;
    logic          dram_req_read, dram_req_write;
    logic [1:0]    grant;
    logic          busy;

    logic [DW-1:0] f_m0_data_in, f_m1_data_in;
    logic          f_m0_data_valid, f_m0_write_complete, f_m0_error;
    logic          f_m1_data_valid, f_m1_write_complete, f_m1_error;
    logic [AW-1:0] f_dram_addr;
    logic [DW-1:0] f_dram_data_out;
    logic          f_dram_req_read, f_dram_req_write;
    logic [1:0]    f_grant;
    logic          f_busy;
    logic          f_dv, f_wc;

    // the fixed-priority instance gets a clean DRAM that answers its own op
    assign f_dv = resp & f_dram_req_read;
    assign f_wc = resp & f_dram_req_write;

    wire [5:0] pv  = {m1_error, m1_write_complete, m1_data_valid,
                      m0_error, m0_write_complete, m0_data_valid};
    wire [5:0] fpv = {f_m1_error, f_m1_write_complete, f_m1_data_valid,
                      f_m0_error, f_m0_write_complete, f_m0_data_valid};

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req_read(m0_req_read), .m0_req_write(m0_req_write),
        .m0_addr(m0_addr), .m0_data_out(m0_data_out),
        .m0_data_in(m0_data_in), .m0_data_valid(m0_data_valid),
        .m0_write_complete(m0_write_complete), .m0_error(m0_error),
        .m1_req_read(m1_req_read), .m1_req_write(m1_req_write),
        .m1_addr(m1_addr), .m1_data_out(m1_data_out),
        .m1_data_in(m1_data_in), .m1_data_valid(m1_data_valid),
        .m1_write_complete(m1_write_complete), .m1_error(m1_error),
        .dram_addr(dram_addr), .dram_data_out(dram_data_out),
        .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
        .dram_data_in(dram_data_in), .dram_data_valid(dram_data_valid),
        .dram_write_complete(dram_write_complete),
        .grant(grant), .busy(busy)
    );

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .TIMEOUT(TO)) u_fix (
        .clk(clk), .rst(rst),
        .m0_req_read(m0_req_read), .m0_req_write(m0_req_write),
        .m0_addr(m0_addr), .m0_data_out(m0_data_out),
        .m0_data_in(f_m0_data_in), .m0_data_valid(f_m0_data_valid),
        .m0_write_complete(f_m0_write_complete), .m0_error(f_m0_error),
        .m1_req_read(m1_req_read), .m1_req_write(m1_req_write),
        .m1_addr(m1_addr), .m1_data_out(m1_data_out),
        .m1_data_in(f_m1_data_in), .m1_data_valid(f_m1_data_valid),
        .m1_write_complete(f_m1_write_complete), .m1_error(f_m1_error),
        .dram_addr(f_dram_addr), .dram_data_out(f_dram_data_out),
        .dram_req_read(f_dram_req_read), .dram_req_write(f_dram_req_write),
        .dram_data_in(dram_data_in), .dram_data_valid(f_dv),
        .dram_write_complete(f_wc),
        .grant(f_grant), .busy(f_busy)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // master-side request model
    bit            act [2];
    bit            mrd [2];
    bit            mwr [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mdat [2];
    int            last;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        m0_req_read  = act[0] & mrd[0];
        m0_req_write = act[0] & mwr[0];
        m0_addr      = maddr[0];
        m0_data_out  = mdat[0];
        m1_req_read  = act[1] & mrd[1];
        m1_req_write = act[1] & mwr[1];
        m1_addr      = maddr[1];
        m1_data_out  = mdat[1];
    endtask

    task automatic set_master(input int m, input bit rd, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        act[m]   = 1'b1;
        mrd[m]   = rd;
        mwr[m]   = wr;
        maddr[m] = a;
        mdat[m]  = d;
    endtask

    task automatic rnd_master(input int m);
        int op;
        op = $urandom_range(0, 2);
        set_master(m, op != 1, op != 0, AW'($urandom), $urandom);
    endtask

    // one transaction from IDLE through DONE back to IDLE;
    // lat = BUSY edge carrying the completion, outside 1..TO means none
    task automatic txn(input int lat, input logic [DW-1:0] val, input bit renew);
        int         w, wf, nend, b, fb;
        bit         ok, wr, fwr;
        logic [1:0] op, fop;
        if (act[0] && act[1]) begin
            w  = 1 - last;
            wf = 0;
        end else begin
            w  = act[0] ? 0 : 1;
            wf = w;
        end
        last = w;
        wr   = mwr[w];
        fwr  = mwr[wf];
        op   = wr ? 2'b10 : 2'b01;
        fop  = fwr ? 2'b10 : 2'b01;
        ok   = (lat >= 1) && (lat <= TO);
        nend = ok ? lat : TO;

        drive();
        step();
        chk("grant", 64'(grant), 64'(1) << w);
        chk("busy", 64'(busy), 64'(1));
        chk("dram_addr", 64'(dram_addr), 64'(maddr[w]));
        chk("dram_wdata", 64'(dram_data_out), 64'(mdat[w]));
        chk("dram_op", 64'({dram_req_write, dram_req_read}), 64'(op));
        chk("f_grant", 64'(f_grant), 64'(1) << wf);
        chk("f_addr", 64'(f_dram_addr), 64'(maddr[wf]));
        chk("f_op", 64'({f_dram_req_write, f_dram_req_read}), 64'(fop));

        for (int k = 1; k <= nend; k++) begin
            resp                = (k == lat);
            dram_data_valid     = (k == lat && !wr) || (wr && $urandom_range(0, 3) == 0);
            dram_write_complete = (k == lat && wr) || (!wr && $urandom_range(0, 3) == 0);
            dram_data_in        = (k == lat) ? val : $urandom;
            step();
            resp                = 1'b0;
            dram_data_valid     = 1'b0;
            dram_write_complete = 1'b0;
            if (k < nend) begin
                chk("hold_op", 64'({dram_req_write, dram_req_read}), 64'(op));
                chk("hold_addr", 64'(dram_addr), 64'(maddr[w]));
                chk("busy_pulse", 64'(pv), 64'(0));
            end
        end

        b  = w * 3 + (ok ? (wr ? 1 : 0) : 2);
        fb = wf * 3 + (ok ? (fwr ? 1 : 0) : 2);
        chk("done_pulse", 64'(pv), 64'(1) << b);
        chk("done_req", 64'({dram_req_write, dram_req_read}), 64'(0));
        chk("done_busy_grant", 64'({busy, grant}), 64'({1'b1, 2'(1 << w)}));
        chk("f_done_pulse", 64'(fpv), 64'(1) << fb);
        if (ok && !wr) begin
            chk("rdata", 64'(w ? m1_data_in : m0_data_in), 64'(val));
        end

        if (!renew) act[w] = 1'b0;
        drive();
        step();
        chk("idle", 64'({grant, busy, dram_req_write, dram_req_read, pv}), 64'(0));
        chk("f_idle", 64'({f_grant, f_busy, fpv}), 64'(0));
    endtask

    initial begin
        rst                 = 1'b1;
        resp                = 1'b0;
        dram_data_valid     = 1'b0;
        dram_write_complete = 1'b0;
        dram_data_in        = '0;
        last                = 1;
        for (int m = 0; m < 2; m++) begin
            act[m]   = 1'b0;
            mrd[m]   = 1'b0;
            mwr[m]   = 1'b0;
            maddr[m] = '0;
            mdat[m]  = '0;
        end
        drive();
        step();
        step();
        chk("rst_ctl", 64'({grant, busy, dram_req_write, dram_req_read, pv}), 64'(0));
        chk("rst_addr", 64'(dram_addr), 64'(0));
        chk("rst_wdata", 64'(dram_data_out), 64'(0));
        chk("rst_rdata", 64'({m1_data_in, m0_data_in}), 64'(0));
        rst = 1'b0;
        step();
        chk("idle_no_req", 64'({grant, busy}), 64'(0));

        // contention from reset: m0, then m1, then m0 again
        set_master(0, 1'b0, 1'b1, 24'h000aa0, 32'h1111_2222);
        set_master(1, 1'b1, 1'b0, 24'h000bb0, 32'h0);
        txn(2, 32'h0, 1'b1);
        txn(4, 32'h5555_aaaa, 1'b0);
        txn(1, 32'h0, 1'b0);

        // single read from the DMA master
        set_master(1, 1'b1, 1'b0, 24'h00f00d, 32'h0);
        txn(3, 32'hdead_beef, 1'b0);
        chk("m0_rdata_untouched", 64'(m0_data_in), 64'(0));

        // single write from the CPU master
        set_master(0, 1'b0, 1'b1, 24'h000010, 32'h0000_beef);
        txn(3, 32'h0, 1'b0);

        // watchdog abort, then completion on the timeout edge
        set_master(1, 1'b1, 1'b0, 24'h123456, 32'h0);
        txn(0, 32'h0, 1'b0);
        set_master(1, 1'b1, 1'b0, 24'h654321, 32'h0);
        txn(TO, 32'hcafe_f00d, 1'b0);

        // randomized traffic with held, pending and renewed requests
        for (int i = 0; i < 150; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 1) == 1) rnd_master(m);
            end
            if (!act[0] && !act[1]) rnd_master(int'($urandom_range(0, 1)));
            txn(int'($urandom_range(1, TO + 3)), $urandom, $urandom_range(0, 2) == 0);
        end
        act[0] = 1'b0;
        act[1] = 1'b0;
        drive();
        step();

        // reset while a write is outstanding
        set_master(0, 1'b0, 1'b1, 24'h0abcde, 32'h7777_0001);
        drive();
        step();
        chk("pre_rst_op", 64'({dram_req_write, dram_req_read}), 64'(2'b10));
        step();
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_ctl", 64'({grant, busy, dram_req_write, dram_req_read, pv}), 64'(0));
        chk("mid_rst_data", 64'({dram_data_out, dram_addr}), 64'(0));
        chk("mid_rst_f", 64'({f_grant, f_busy, f_dram_req_write, fpv}), 64'(0));
        rst  = 1'b0;
        last = 1;
        txn(2, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-master arbiter for the shared DRAM request port.
- Master 0 is the CPU/cache side; master 1 is dma_controller.
- Grants one transaction at a time, round-robin on contention. Registers the winning address, data and opcode onto the DRAM controller interface, then routes completion back to the granted master.
- A watchdog aborts a transaction the DRAM controller never completes.

Parameters:
- ADDR_W, 24, DRAM address width.
- DATA_W, 32, DRAM data width.
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 0 always wins ties.
- TIMEOUT, 1024: cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- m0_req_read  in  1  master 0 read request; level, held until completion/error
- m0_req_write  in  1  master 0 write request; level, held until completion/error
- m0_addr  in  ADDR_W  master 0 address; stable while request is held
- m0_data_out  in  DATA_W  master 0 write data
- m0_data_in  out  DATA_W  read data returned to master 0
- m0_data_valid  out  1  one-cycle pulse; m0_data_in valid
- m0_write_complete  out  1  one-cycle pulse; write done
- m0_error  out  1  one-cycle pulse; transaction timed out
- m1_*  (same eight signals)  master 1 (DMA)
- dram_addr  out  ADDR_W  to DRAM controller
- dram_data_out  out  DATA_W  to DRAM controller
- dram_req_read  out  1  to DRAM controller
- dram_req_write  out  1  to DRAM controller
- dram_data_in  in  DATA_W  from DRAM controller
- dram_data_valid  in  1  from DRAM controller; one-cycle completion
- dram_write_complete  in  1  from DRAM controller; one-cycle completion
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high in BUSY and DONE

Behaviour:
- Reset: state IDLE, grant=00, busy=0, all dram_req_*/pulses=0, dram_addr/dram_data_out/mN_data_in=0, last_grant=1 (master 0 wins first tie). Reset mid-transaction drops dram_req_* on the next edge; no completion or error pulse is issued.
- States: IDLE, BUSY, DONE.
- IDLE: a master is requesting if req_read|req_write. Grant selection:
  - one requester: grant it;
  - both requesting: the master != last_grant wins (FIXED_PRIO=1: master 0 wins).
- On the grant edge: latch addr/data into dram_addr/dram_data_out; assert dram_req_write if the master's req_write, else dram_req_read. Write wins if a master asserts both. Set grant, update last_grant, clear watchdog, state to BUSY.
- Request-to-DRAM latency: 1 cycle.
- BUSY: dram_req_* held constant, and dram_addr/dram_data_out stay stable.
  - Read: dram_data_valid at edge → mN_data_in <= dram_data_in, mN_data_valid <= 1.
  - Write: dram_write_complete at edge → mN_write_complete <= 1.
  - Either completion drops dram_req_* and moves state to DONE. Completion signals of the non-active type are ignored.
- Watchdog: counts BUSY cycles. When the count reaches TIMEOUT with no completion: drop dram_req_*, pulse mN_error, state to DONE. A completion arriving on the same edge as the timeout wins; no error is raised.
- DONE: exactly one cycle. Completion/error pulse is visible here and requests are ignored. Next edge: grant=00, state to IDLE. The master must drop or renew its request by that edge; a request seen in IDLE is a new transaction.
- Back-to-back throughput: 1 DRAM request per (DRAM latency + 2) cycles.
- The non-granted master's outputs stay 0; its request is held pending and never lost.

Test Plan:
- Single read: m1 read addr 0x00f00d; DRAM returns 0xdeadbeef 3 cycles after dram_req_read → dram_addr=0x00f00d one cycle after request; m1_data_valid one pulse with m1_data_in=0xdeadbeef; m0 outputs stay 0.
- Contention round-robin: m0 write and m1 read both asserted from reset → m0 granted first. After DONE, m1 granted. m0 re-requests at once → m0 granted third; grant sequence 01,10,01.
- FIXED_PRIO=1: both masters hold continuous requests → m0 granted every time and m1 starves; checks the parameter.
- Write completion: m0 write 0x000010 data 0x0000beef; dram_write_complete 30 ns after req → dram_data_out=0x0000beef; m0_write_complete pulses once; dram_req_write low the following cycle.
- Timeout, TIMEOUT=8: m1 read with no DRAM response → dram_req_read high exactly 8 cycles, then m1_error pulse, busy clears after DONE. A second run with completion on the 8th cycle → data_valid pulse, no error.
- Reset mid-BUSY: assert rst while dram_req_write high → next edge all outputs 0, grant=00. After release, a pending m0 request is regranted.
